int_dispatch: RTL and testbench

//  Interrupt dispatcher for the 32-source interrupt controller path. Arbitrates

---
 rtl/int_dispatch_pkg.sv | 22 ++
 rtl/int_dispatch_rr_arbiter.sv | 37 +++
 rtl/int_dispatch.sv | 160 ++++++++++++++++
 tb/tb_int_dispatch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_dispatch_pkg.sv
// Shared types and register map for the interrupt dispatcher.
package int_dispatch_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_CLEAR  = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MASK_LO = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK_HI = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EOI     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd5;

endpackage

// File: rtl/int_dispatch_rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin from ptr.
module int_dispatch_rr_arbiter #(
    parameter int unsigned NUM_SRC = 32,
    parameter int unsigned VEC_W   = 5
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [VEC_W-1:0]   ptr,
    input  logic               mode,
    output logic               gnt_valid,
    output logic [VEC_W-1:0]   gnt_idx
);

    int unsigned start_idx;
    int unsigned idx;

    // Ascending search from the start index, wrapping at NUM_SRC; first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        start_idx = mode ? 32'(ptr) : 32'd0;
        if (start_idx >= NUM_SRC) begin
            start_idx = 0;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = start_idx + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!gnt_valid && req[VEC_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = VEC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/int_dispatch.sv
// Interrupt dispatcher: arbitration, claim/EOI sequencing and bus registers.
module int_dispatch
    import int_dispatch_pkg::*;
#(
    parameter int unsigned NUM_SRC = 32,
    parameter int unsigned VEC_W   = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] DataRd,
    input  logic [DATA_W-1:0] DataWr,
    input  logic              En,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [STAT_W-1:0] IntStatus,
    output logic [STAT_W-1:0] IntReset,
    output logic              Int
);

    state_e              state_q, state_d;
    logic [STAT_W-1:0]   mask_q, mask_d;
    logic                mode_q, mode_d;
    logic [VEC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;
    logic                int_q, int_d;
    logic [STAT_W-1:0]   intreset_q, intreset_d;

    logic [NUM_SRC-1:0]  pend;
    logic                gnt_valid;
    logic [VEC_W-1:0]    gnt_idx;
    logic                wr_en;
    logic                claim;
    logic                rd_status;
    logic                eoi_wr;

    assign pend      = IntStatus[NUM_SRC-1:0] & mask_q[NUM_SRC-1:0];
    assign wr_en     = En & Wr;
    assign claim     = En & Rd & (Addr == ADDR_VECTOR) & (state_q == ST_PEND);
    assign rd_status = En & Rd & (Addr == ADDR_STATUS);
    assign eoi_wr    = wr_en & (Addr == ADDR_EOI) & (state_q == ST_ACTIVE);

    int_dispatch_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_arb (
        .req       (pend),
        .ptr       (rr_ptr_q),
        .mode      (mode_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state, register updates and registered output values.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        rr_ptr_d   = rr_ptr_q;
        vec_d      = vec_q;
        err_d      = err_q;
        hold_d     = 1'b0;
        int_d      = 1'b0;
        intreset_d = '0;

        if (wr_en) begin
            case (Addr)
                ADDR_MASK_LO: mask_d[DATA_W-1:0]      = DataWr;
                ADDR_MASK_HI: mask_d[STAT_W-1:DATA_W] = DataWr;
                ADDR_CTRL:    mode_d                  = DataWr[0];
                default:      ;
            endcase
        end

        if (rd_status) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // One quiet cycle after a clear lets the source status fall.
                if (!hold_q && gnt_valid) begin
                    vec_d   = gnt_idx;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (claim) begin
                    state_d = ST_ACTIVE;
                end else if (!pend[vec_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (eoi_wr) begin
                    if (DataWr[VEC_W-1:0] == vec_q) begin
                        state_d = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                rr_ptr_d = (vec_q == VEC_W'(NUM_SRC - 1)) ? '0 : VEC_W'(vec_q + 1'b1);
                hold_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        int_d = (state_d == ST_PEND);
        if (state_d == ST_CLEAR) begin
            intreset_d = STAT_W'(1) << vec_q;
        end
    end

    // State and register flops.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            mode_q     <= 1'b0;
            rr_ptr_q   <= '0;
            vec_q      <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            int_q      <= 1'b0;
            intreset_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            rr_ptr_q   <= rr_ptr_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            int_q      <= int_d;
            intreset_q <= intreset_d;
        end
    end

    // Read data decode, combinational from address and state.
    always_comb begin
        DataRd = '0;
        case (Addr)
            ADDR_MASK_LO: DataRd = mask_q[DATA_W-1:0];
            ADDR_MASK_HI: DataRd = mask_q[STAT_W-1:DATA_W];
            ADDR_VECTOR:  DataRd = (state_q == ST_PEND) ? (DATA_W'(vec_q) | 16'h8000) : '0;
            ADDR_STATUS:  DataRd = DATA_W'({err_q, state_q, mode_q});
            ADDR_CTRL:    DataRd = DATA_W'(mode_q);
            default:      DataRd = '0;
        endcase
    end

    assign Int      = int_q;
    assign IntReset = intreset_q;

endmodule

// File: tb/tb_int_dispatch.sv
// Self-checking bench for int_dispatch: directed scenarios plus randomized dispatches.
module tb_int_dispatch;

    localparam logic [2:0] A_MASK_LO = 3'd0;
    localparam logic [2:0] A_MASK_HI = 3'd1;
    localparam logic [2:0] A_VECTOR  = 3'd2;
    localparam logic [2:0] A_EOI     = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;
    localparam logic [2:0] A_CTRL    = 3'd5;
    localparam logic [2:0] A_UNUSED  = 3'd6;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [2:0]  Addr;
    logic [15:0] DataRd;
    logic [15:0] DataWr;
    logic        En, Rd, Wr;
    logic [31:0] IntStatus;
    logic [31:0] IntReset;
    logic        Int;

    int          vectors     = 0;
    int          miscompares = 0;

    // Reference model state
    logic [31:0] model_mask;
    bit          model_mode;
    int          model_ptr;

    int_dispatch u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Addr      (Addr),
        .DataRd    (DataRd),
        .DataWr    (DataWr),
        .En        (En),
        .Rd        (Rd),
        .Wr        (Wr),
        .IntStatus (IntStatus),
        .IntReset  (IntReset),
        .Int       (Int)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
        @(posedge Clk);
        #1;
        En = 1'b0; Wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
        Addr = a; En = 1'b1; Rd = 1'b1;
        #1;
        d = DataRd;
        @(posedge Clk);
        #1;
        En = 1'b0; Rd = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        Addr = a;
        #1;
        d = DataRd;
    endtask

    // Winner by rule: lowest index in fixed mode, first at/after ptr (wrapping) in round-robin.
    function automatic int winner(input logic [31:0] p, input bit rr, input int ptr);
        for (int i = 0; i < 32; i++) begin
            int k;
            k = rr ? (ptr + i) % 32 : i;
            if (((p >> k) & 32'd1) != 32'd0) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] stat(input int err, input int st);
        return 32'((err << 3) | (st << 1) | int'(model_mode));
    endfunction

    task automatic set_cfg(input logic [31:0] m, input bit md);
        bus_wr(A_MASK_LO, m[15:0]);
        bus_wr(A_MASK_HI, m[31:16]);
        bus_wr(A_CTRL, {15'b0, md});
        model_mask = m;
        model_mode = md;
    endtask

    // Entered just after the DUT went PEND on vector v: claim, optional bad EOI, good EOI, clear.
    task automatic serve(input int v, input int bad, input bit drop);
        logic [15:0] d;
        chk("int_pend", 32'(Int), 32'd1);
        bus_rd(A_VECTOR, d);
        chk("vector_claim", 32'(d), 32'h8000 | 32'(v));
        chk("int_after_claim", 32'(Int), 32'd0);
        peek(A_VECTOR, d);
        chk("vector_active", 32'(d), 32'd0);
        if (bad >= 0) begin
            bus_wr(A_EOI, 16'(bad));
            chk("ireset_bad_eoi", IntReset, 32'd0);
            bus_rd(A_STATUS, d);
            chk("status_err_set", 32'(d), stat(1, 2));
            bus_rd(A_STATUS, d);
            chk("status_err_clr", 32'(d), stat(0, 2));
        end
        bus_wr(A_EOI, 16'(v));
        chk("ireset_pulse", IntReset, 32'd1 << v);
        peek(A_STATUS, d);
        chk("status_clear", 32'(d), stat(0, 3));
        if (drop) IntStatus = IntStatus & ~(32'd1 << v);
        tick();
        chk("ireset_off", IntReset, 32'd0);
        chk("int_idle", 32'(Int), 32'd0);
        tick();
        chk("int_hold", 32'(Int), 32'd0);
        model_ptr = (v + 1) % 32;
    endtask

    initial begin
        logic [15:0] d;
        int          e;

        Reset = 1'b0; En = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataWr = '0;
        IntStatus = '0; model_mask = '0; model_mode = 1'b0; model_ptr = 0;
        #12;
        chk("rst_int", 32'(Int), 32'd0);
        chk("rst_ireset", IntReset, 32'd0);
        peek(A_STATUS, d);  chk("rst_status", 32'(d), 32'd0);
        peek(A_MASK_LO, d); chk("rst_mask_lo", 32'(d), 32'd0);
        peek(A_MASK_HI, d); chk("rst_mask_hi", 32'(d), 32'd0);
        peek(A_VECTOR, d);  chk("rst_vector", 32'(d), 32'd0);
        Reset = 1'b1;
        tick();

        // Fixed priority: 0 then 2, register readback and unused address
        set_cfg(32'h0000_0005, 1'b0);
        peek(A_MASK_LO, d); chk("mask_lo_rb", 32'(d), 32'h5);
        bus_wr(A_UNUSED, 16'hFFFF);
        peek(A_UNUSED, d);  chk("unused_addr", 32'(d), 32'd0);
        IntStatus = 32'h5;
        chk("int_latency", 32'(Int), 32'd0);
        tick();
        serve(winner(IntStatus & model_mask, model_mode, model_ptr), -1, 1'b1);
        tick();
        serve(winner(IntStatus & model_mask, model_mode, model_ptr), -1, 1'b1);

        // Round-robin alternation with status held
        set_cfg(32'h0000_0003, 1'b1);
        peek(A_CTRL, d); chk("ctrl_rb", 32'(d), 32'd1);
        IntStatus = 32'h3;
        tick();
        for (int i = 0; i < 4; i++) begin
            serve(winner(IntStatus & model_mask, model_mode, model_ptr), -1, 1'b0);
            if (i < 3) tick();
        end
        IntStatus = '0;
        tick();

        // Spurious drop before claim
        set_cfg(32'h0000_0080, 1'b0);
        IntStatus = 32'h80;
        tick();
        chk("spur_int", 32'(Int), 32'd1);
        peek(A_VECTOR, d); chk("spur_vector", 32'(d), 32'h8007);
        IntStatus = '0;
        tick();
        chk("spur_int_fall", 32'(Int), 32'd0);
        chk("spur_ireset", IntReset, 32'd0);
        peek(A_STATUS, d); chk("spur_status", 32'(d), stat(0, 0));
        tick();
        chk("spur_stay_idle", 32'(Int), 32'd0);

        // Mismatched EOI sets sticky error
        set_cfg(32'h0000_0008, 1'b0);
        IntStatus = 32'h8;
        tick();
        serve(3, 4, 1'b1);

        // Asynchronous reset while ACTIVE
        set_cfg(32'h0000_0010, 1'b0);
        IntStatus = 32'h10;
        tick();
        chk("rst5_int", 32'(Int), 32'd1);
        bus_rd(A_VECTOR, d); chk("rst5_claim", 32'(d), 32'h8004);
        Reset = 1'b0;
        #1;
        chk("rst5_int_low", 32'(Int), 32'd0);
        chk("rst5_ireset", IntReset, 32'd0);
        peek(A_MASK_LO, d); chk("rst5_mask", 32'(d), 32'd0);
        peek(A_STATUS, d);  chk("rst5_status", 32'(d), 32'd0);
        #1;
        Reset = 1'b1;
        model_mask = '0; model_mode = 1'b0; model_ptr = 0;
        tick();
        tick();
        chk("rst5_no_dispatch", 32'(Int), 32'd0);
        bus_wr(A_MASK_LO, 16'h0010);
        model_mask = 32'h10;
        chk("rst5_mask_lat", 32'(Int), 32'd0);
        tick();
        serve(4, -1, 1'b1);

        // Round-robin pointer wrap after vector 31
        set_cfg(32'h8000_0001, 1'b1);
        IntStatus = 32'h8000_0000;
        tick();
        serve(winner(IntStatus & model_mask, model_mode, model_ptr), -1, 1'b1);
        IntStatus = 32'h8000_0001;
        tick();
        e = winner(IntStatus & model_mask, model_mode, model_ptr);
        serve(e, -1, 1'b1);
        IntStatus = '0;
        tick();

        // Randomized dispatches against the model
        for (int it = 0; it < 40; it++) begin
            logic [31:0] m, s;
            int          k, bad;
            IntStatus = '0;
            tick();
            k = int'($urandom_range(0, 31));
            m = $urandom() | (32'd1 << k);
            s = $urandom() | (32'd1 << k);
            set_cfg(m, 1'($urandom_range(0, 1)));
            IntStatus = s;
            chk("rnd_latency", 32'(Int), 32'd0);
            tick();
            e = winner(s & m, model_mode, model_ptr);
            if ($urandom_range(0, 3) == 0) begin
                chk("rnd_spur_int", 32'(Int), 32'd1);
                peek(A_VECTOR, d); chk("rnd_spur_vec", 32'(d), 32'h8000 | 32'(e));
                IntStatus = IntStatus & ~(32'd1 << e);
                tick();
                chk("rnd_spur_fall", 32'(Int), 32'd0);
                chk("rnd_spur_ireset", IntReset, 32'd0);
                tick();
                if ((IntStatus & m) == 32'd0) begin
                    chk("rnd_spur_idle", 32'(Int), 32'd0);
                    continue;
                end
                e = winner(IntStatus & m, model_mode, model_ptr);
            end
            bad = ($urandom_range(0, 2) == 0) ? (e + 1 + int'($urandom_range(0, 30))) % 32 : -1;
            serve(e, bad, 1'b1);
        end
        IntStatus = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
